// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// One shared subtractor performs one restoring-division step per clock.
// A start/done handshake lets a controller issue divides back to back.
// A zero divisor completes in one cycle with an all-ones quotient and a flag.

module subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // Widen by one bit so the carry-out of a - b becomes the borrow.
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

module restoring_divider #(
    parameter int N = 4
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   count_r;
    logic [N-1:0]    rem_r;
    logic [N-1:0]    quo_r;
    logic [N-1:0]    dvs_r;

    logic [N:0]      trial_s;
    logic [N:0]      diff_s;
    logic            borrow_s;
    logic            restore_s;
    logic [N-1:0]    next_rem_s;
    logic [N-1:0]    next_quo_s;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial_s = {rem_r, quo_r[N-1]};

    subtractor #(
        .W (N + 1)
    ) u_sub (
        .a      (trial_s),
        .b      ({1'b0, dvs_r}),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // A valid difference always fits in N bits; anything wider is treated as
    // a failed trial so the working remainder can never exceed N bits.
    assign restore_s = borrow_s | diff_s[N];

    // Choose between the trial difference and the restored remainder.
    always_comb begin
        next_rem_s = trial_s[N-1:0];
        next_quo_s = {quo_r[N-2:0], 1'b0};
        if (restore_s) begin
            next_rem_s = trial_s[N-1:0];
            next_quo_s = {quo_r[N-2:0], 1'b0};
        end else begin
            next_rem_s = diff_s[N-1:0];
            next_quo_s = {quo_r[N-2:0], 1'b1};
        end
    end

    // Control FSM, working registers and registered result/handshake outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r       <= ST_IDLE;
            count_r       <= '0;
            rem_r         <= '0;
            quo_r         <= '0;
            dvs_r         <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // The DONE cycle accepts a new request exactly like IDLE.
                    if (i_start) begin
                        if (i_divisor != {N{1'b0}}) begin
                            state_r <= ST_RUN;
                            count_r <= '0;
                            rem_r   <= '0;
                            quo_r   <= i_dividend;
                            dvs_r   <= i_divisor;
                            o_busy  <= 1'b1;
                            o_done  <= 1'b0;
                        end else begin
                            state_r       <= ST_DONE;
                            o_busy        <= 1'b0;
                            o_done        <= 1'b1;
                            o_quotient    <= {N{1'b1}};
                            o_remainder   <= i_dividend;
                            o_div_by_zero <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    rem_r   <= next_rem_s;
                    quo_r   <= next_quo_s;
                    count_r <= count_r + CW'(1);
                    if (count_r == CW'(N - 1)) begin
                        state_r       <= ST_DONE;
                        count_r       <= '0;
                        o_busy        <= 1'b0;
                        o_done        <= 1'b1;
                        o_quotient    <= next_quo_s;
                        o_remainder   <= next_rem_s;
                        o_div_by_zero <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        o_busy  <= 1'b1;
                        o_done  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= '0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
